xbus_ifmap_ctrl: RTL and testbench

Sequencer for one ifmap XBus.
- Phase 1: loads the PE ID scan chain by shifting one ID per cycle, highest PE index first.
- Phase 2: streams a programmed number of tagged ifmap words from an upstream valid/ready source onto the bus enable/ready handshake, through a one-entry output register.
- Sits between the global-buffer read path and the XBus; one instance per row bus, driven by the top-level layer controller.

---
 rtl/xbus_ifmap_ctrl.sv | 177 +++++++++++++++++
 tb/tb_xbus_ifmap_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/xbus_ifmap_ctrl.sv
// -----------------------------------------------------------------------------
// xbus_ifmap_ctrl
// Sequencer for one ifmap XBus row. A run first optionally loads the PE ID
// scan chain, shifting one ID per cycle with the highest PE index first. It then
// streams a programmed number of tagged ifmap words from an upstream
// valid/ready source onto the XBus enable/ready handshake. The words pass
// through a one-entry output register.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   start             : one-cycle start pulse, only honoured in IDLE
//   cfg_scan          : 1 = run the ID scan before streaming
//   cfg_len           : number of words to stream (captured with start)
//   cfg_ids           : ID table, entry i at [i*ID_LEN +: ID_LEN] (captured)
//   src_valid/ready   : upstream handshake
//   src_tag/src_value : upstream word
//   xbus_enable/ready : bus handshake
//   xbus_tag_value    : {tag, value} presented on the bus
//   xbus_set_id       : ID scan-load strobe
//   xbus_id_scan_in   : ID shifted into the chain this cycle
//   busy              : high outside IDLE
//   done              : one-cycle completion pulse
// -----------------------------------------------------------------------------
module xbus_ifmap_ctrl #(
   parameter int PE_NUMS   = 14,
   parameter int ID_LEN    = 5,
   parameter int VALUE_LEN = 32,
   parameter int LEN_W     = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic                          cfg_scan,
   input  logic [LEN_W-1:0]              cfg_len,
   input  logic [PE_NUMS*ID_LEN-1:0]     cfg_ids,
   input  logic                          src_valid,
   output logic                          src_ready,
   input  logic [ID_LEN-1:0]             src_tag,
   input  logic [VALUE_LEN-1:0]          src_value,
   output logic                          xbus_enable,
   input  logic                          xbus_ready,
   output logic [VALUE_LEN+ID_LEN-1:0]   xbus_tag_value,
   output logic                          xbus_set_id,
   output logic [ID_LEN-1:0]             xbus_id_scan_in,
   output logic                          busy,
   output logic                          done
);

   localparam int KW = (PE_NUMS > 1) ? $clog2(PE_NUMS) : 1;
   localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
   localparam logic [LEN_W-1:0] LEN_ZERO = '0;
   localparam logic [KW-1:0]    K_LAST   = KW'(PE_NUMS - 1);
   localparam logic [KW-1:0]    K_ONE    = {{(KW-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SCAN   = 3'd1,
      S_STREAM = 3'd2,
      S_DRAIN  = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t                          r_state;
   state_t                          w_next;

   logic [KW-1:0]                   r_scan_k;
   logic [LEN_W-1:0]                r_len;
   logic [LEN_W-1:0]                r_accept_cnt;
   logic [LEN_W-1:0]                r_send_cnt;
   logic [PE_NUMS*ID_LEN-1:0]       r_ids;
   logic                            r_buf_valid;
   logic [VALUE_LEN+ID_LEN-1:0]     r_buf_data;

   logic                            w_src_ready;
   logic                            w_up_hs;
   logic                            w_bus_hs;
   logic                            w_last_accept;
   logic                            w_last_send;

   // The buffer can take a new word when it is empty or being emptied this
   // cycle, so a simultaneous bus and upstream handshake runs at full rate.
   assign w_src_ready   = (r_state == S_STREAM) && (!r_buf_valid || xbus_ready) &&
                          (r_accept_cnt < r_len);
   assign w_up_hs       = src_valid && w_src_ready;
   assign w_bus_hs      = r_buf_valid && xbus_ready;
   assign w_last_accept = w_up_hs && ((r_accept_cnt + LEN_ONE) == r_len);
   assign w_last_send   = w_bus_hs && ((r_send_cnt + LEN_ONE) == r_len);

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               if (cfg_scan)                w_next = S_SCAN;
               else if (cfg_len == LEN_ZERO) w_next = S_DONE;
               else                         w_next = S_STREAM;
            end
         end
         S_SCAN: begin
            if (r_scan_k == '0) begin
               w_next = (r_len == LEN_ZERO) ? S_DONE : S_STREAM;
            end
         end
         S_STREAM: begin
            if (w_last_accept) w_next = S_DRAIN;
         end
         S_DRAIN: begin
            if (w_last_send) w_next = S_DONE;
         end
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Output logic: decoded from state, the captured ID table and the buffer
   always_comb begin
      busy            = (r_state != S_IDLE);
      done            = (r_state == S_DONE);
      xbus_set_id     = (r_state == S_SCAN);
      xbus_id_scan_in = '0;
      if (r_state == S_SCAN) begin
         xbus_id_scan_in = r_ids[r_scan_k*ID_LEN +: ID_LEN];
      end
      src_ready       = w_src_ready;
      xbus_enable     = r_buf_valid;
      xbus_tag_value  = r_buf_data;
   end

   // Configuration capture, scan index, transfer counters and output buffer.
   // Buffer data is also cleared so that every output reads 0 out of reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_scan_k     <= '0;
         r_len        <= '0;
         r_ids        <= '0;
         r_accept_cnt <= '0;
         r_send_cnt   <= '0;
         r_buf_valid  <= 1'b0;
         r_buf_data   <= '0;
      end else begin
         if ((r_state == S_IDLE) && start) begin
            r_len        <= cfg_len;
            r_ids        <= cfg_ids;
            r_accept_cnt <= '0;
            r_send_cnt   <= '0;
            r_scan_k     <= K_LAST;
         end
         if ((r_state == S_SCAN) && (r_scan_k != '0)) begin
            r_scan_k <= r_scan_k - K_ONE;
         end
         if (w_up_hs) begin
            r_accept_cnt <= r_accept_cnt + LEN_ONE;
            r_buf_data   <= {src_tag, src_value};
         end
         if (w_bus_hs) begin
            r_send_cnt <= r_send_cnt + LEN_ONE;
         end
         // A reload in the same cycle as a bus handshake keeps the buffer full.
         if (w_up_hs) begin
            r_buf_valid <= 1'b1;
         end else if (w_bus_hs) begin
            r_buf_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_xbus_ifmap_ctrl.sv
// -----------------------------------------------------------------------------
// Directed testbench for xbus_ifmap_ctrl (PE_NUMS=14, ID_LEN=5, VALUE_LEN=32).
// -----------------------------------------------------------------------------
module tb_xbus_ifmap_ctrl;

   localparam int PE_NUMS   = 14;
   localparam int ID_LEN    = 5;
   localparam int VALUE_LEN = 32;
   localparam int LEN_W     = 16;

   logic                          clk;
   logic                          rst;
   logic                          start;
   logic                          cfg_scan;
   logic [LEN_W-1:0]              cfg_len;
   logic [PE_NUMS*ID_LEN-1:0]     cfg_ids;
   logic                          src_valid;
   logic                          src_ready;
   logic [ID_LEN-1:0]             src_tag;
   logic [VALUE_LEN-1:0]          src_value;
   logic                          xbus_enable;
   logic                          xbus_ready;
   logic [VALUE_LEN+ID_LEN-1:0]   xbus_tag_value;
   logic                          xbus_set_id;
   logic [ID_LEN-1:0]             xbus_id_scan_in;
   logic                          busy;
   logic                          done;

   int n_vec;
   int n_err;

   logic [PE_NUMS*ID_LEN-1:0]     id_tab;
   logic [PE_NUMS*ID_LEN-1:0]     id_alt;

   xbus_ifmap_ctrl #(
      .PE_NUMS   (PE_NUMS),
      .ID_LEN    (ID_LEN),
      .VALUE_LEN (VALUE_LEN),
      .LEN_W     (LEN_W)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .start           (start),
      .cfg_scan        (cfg_scan),
      .cfg_len         (cfg_len),
      .cfg_ids         (cfg_ids),
      .src_valid       (src_valid),
      .src_ready       (src_ready),
      .src_tag         (src_tag),
      .src_value       (src_value),
      .xbus_enable     (xbus_enable),
      .xbus_ready      (xbus_ready),
      .xbus_tag_value  (xbus_tag_value),
      .xbus_set_id     (xbus_set_id),
      .xbus_id_scan_in (xbus_id_scan_in),
      .busy            (busy),
      .done            (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_srdy"},   64'(src_ready),       64'd0);
      check({tag, "_en"},     64'(xbus_enable),     64'd0);
      check({tag, "_tv"},     64'(xbus_tag_value),  64'd0);
      check({tag, "_setid"},  64'(xbus_set_id),     64'd0);
      check({tag, "_scanin"}, 64'(xbus_id_scan_in), 64'd0);
      check({tag, "_busy"},   64'(busy),            64'd0);
      check({tag, "_done"},   64'(done),            64'd0);
   endtask

   // Runs a stream already started. mode 0: src_valid=1, xbus_ready 1,0,0,1,...
   // mode 1: xbus_ready=1, src_valid random. Words carry tag=n, value=base+n.
   task automatic stream_run(input int len, input int mode, input int base);
      int  acc;
      int  snd;
      logic hold;
      logic [VALUE_LEN+ID_LEN-1:0] hold_val;
      logic up;
      logic bus;
      acc = 0;
      snd = 0;
      hold = 1'b0;
      hold_val = '0;
      for (int cyc = 0; cyc < 300; cyc++) begin
         if (mode == 0) xbus_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
         else           xbus_ready = 1'b1;
         src_valid = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         src_tag   = ID_LEN'(acc);
         src_value = VALUE_LEN'(base + acc);
         #1;
         if (hold) begin
            check("hold_en",   64'(xbus_enable),    64'd1);
            check("hold_data", 64'(xbus_tag_value), 64'(hold_val));
         end
         if (xbus_enable && !xbus_ready) check("full_srdy", 64'(src_ready), 64'd0);
         if (acc == len) check("srdy_after_len", 64'(src_ready), 64'd0);
         check("no_setid", 64'(xbus_set_id), 64'd0);
         up  = src_valid && src_ready;
         bus = xbus_enable && xbus_ready;
         if (bus) begin
            check("bus_word", 64'(xbus_tag_value),
                  64'({ID_LEN'(snd), VALUE_LEN'(base + snd)}));
            snd++;
         end
         if (up) acc++;
         hold     = xbus_enable && !xbus_ready;
         hold_val = xbus_tag_value;
         tick();
         if (done) break;
      end
      src_valid = 1'b0;
      check("accept_count", 64'(acc), 64'(len));
      check("send_count",   64'(snd), 64'(len));
      check("done_pulse",   64'(done), 64'd1);
      check("done_noen",    64'(xbus_enable), 64'd0);
      tick();
      check("done_clear",   64'(done), 64'd0);
      check("busy_clear",   64'(busy), 64'd0);
   endtask

   initial begin
      n_vec      = 0;
      n_err      = 0;
      rst        = 1'b1;
      start      = 1'b0;
      cfg_scan   = 1'b0;
      cfg_len    = '0;
      cfg_ids    = '0;
      src_valid  = 1'b0;
      src_tag    = '0;
      src_value  = '0;
      xbus_ready = 1'b0;
      for (int i = 0; i < PE_NUMS; i++) begin
         id_tab[i*ID_LEN +: ID_LEN] = ID_LEN'(i);
      end
      id_alt = '1;

      // Reset state
      tick(); tick(); tick();
      check_all_zero("reset");
      rst = 1'b0;
      tick();
      check("idle_busy", 64'(busy), 64'd0);

      // Zero-length run without scan goes straight to DONE
      start = 1'b1; cfg_scan = 1'b0; cfg_len = 16'd0;
      tick();
      start = 1'b0;
      check("len0_done",  64'(done), 64'd1);
      check("len0_busy",  64'(busy), 64'd1);
      check("len0_srdy",  64'(src_ready), 64'd0);
      tick();
      check("len0_done_clr", 64'(done), 64'd0);
      check("len0_busy_clr", 64'(busy), 64'd0);

      // Scan order 13..0, with an ignored start carrying different config
      start = 1'b1; cfg_scan = 1'b1; cfg_len = 16'd0; cfg_ids = id_tab;
      tick();
      start = 1'b0;
      for (int k = PE_NUMS - 1; k >= 0; k--) begin
         check("scan_setid",  64'(xbus_set_id),     64'd1);
         check("scan_id",     64'(xbus_id_scan_in), 64'(k));
         check("scan_noen",   64'(xbus_enable),     64'd0);
         check("scan_busy",   64'(busy),            64'd1);
         check("scan_nodone", 64'(done),            64'd0);
         if (k == 10) begin
            start = 1'b1; cfg_scan = 1'b0; cfg_len = 16'd5; cfg_ids = id_alt;
         end else begin
            start = 1'b0;
         end
         tick();
      end
      start = 1'b0; cfg_ids = id_tab;
      check("scan_done",     64'(done),        64'd1);
      check("scan_setid_lo", 64'(xbus_set_id), 64'd0);
      check("scan_done_en",  64'(xbus_enable), 64'd0);
      for (int j = 0; j < 4; j++) begin
         tick();
         check("scan_one_done", 64'(done), 64'd0);
         check("scan_idle",     64'(busy), 64'd0);
         check("scan_idle_en",  64'(xbus_enable), 64'd0);
      end

      // Full-rate stream of 8 words
      start = 1'b1; cfg_scan = 1'b0; cfg_len = 16'd8;
      tick();
      start = 1'b0;
      for (int c = 0; c <= 8; c++) begin
         src_valid  = 1'b1;
         xbus_ready = 1'b1;
         src_tag    = ID_LEN'(c);
         src_value  = VALUE_LEN'(32'h100 + c);
         #1;
         check("fr_srdy", 64'(src_ready),   64'(c < 8));
         check("fr_en",   64'(xbus_enable), 64'(c > 0));
         if (c > 0) begin
            check("fr_word", 64'(xbus_tag_value),
                  64'({ID_LEN'(c - 1), VALUE_LEN'(32'h100 + c - 1)}));
         end
         check("fr_nodone", 64'(done), 64'd0);
         tick();
      end
      src_valid = 1'b0;
      check("fr_done",    64'(done),        64'd1);
      check("fr_done_en", 64'(xbus_enable), 64'd0);
      tick();
      check("fr_done_clr", 64'(done), 64'd0);
      check("fr_busy_clr", 64'(busy), 64'd0);

      // Scan followed by a short stream: STREAM opens right after the last ID
      start = 1'b1; cfg_scan = 1'b1; cfg_len = 16'd3;
      tick();
      start = 1'b0;
      for (int k = 0; k < PE_NUMS; k++) tick();
      check("ss_setid_lo", 64'(xbus_set_id), 64'd0);
      check("ss_srdy",     64'(src_ready),   64'd1);
      stream_run(3, 1, 32'h300);

      // Backpressure
      start = 1'b1; cfg_scan = 1'b0; cfg_len = 16'd4;
      tick();
      start = 1'b0;
      stream_run(4, 0, 32'h200);

      // Upstream bubbles
      start = 1'b1; cfg_scan = 1'b0; cfg_len = 16'd16;
      tick();
      start = 1'b0;
      stream_run(16, 1, 32'h400);

      // Reset mid-stream, then a normal run
      start = 1'b1; cfg_scan = 1'b0; cfg_len = 16'd10;
      src_valid = 1'b1; xbus_ready = 1'b1;
      src_tag = 5'd1; src_value = 32'hdead_beef;
      tick();
      start = 1'b0;
      tick(); tick();
      check("mid_busy", 64'(busy),        64'd1);
      check("mid_en",   64'(xbus_enable), 64'd1);
      rst = 1'b1;
      for (int j = 0; j < 3; j++) begin
         tick();
         check_all_zero("midrst");
      end
      rst = 1'b0;
      src_valid = 1'b0;
      tick();
      check_all_zero("post_rst");
      start = 1'b1; cfg_scan = 1'b0; cfg_len = 16'd2;
      tick();
      start = 1'b0;
      stream_run(2, 1, 32'h500);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
